// File: rtl/count_seq_monitor_pkg.sv
// Shared types and helpers for the counter sequence monitor.
// Holds the FSM state encoding, default widths and the saturating increment.
package count_mon_pkg;

    localparam int CW_DEF    = 4;
    localparam int STATW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_e;

    // Widths up to 31 bits; callers zero-extend into and truncate out of 32 bits.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] maxv);
        return (v == maxv) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/count_seq_monitor_sat_counter.sv
// Saturating statistics counter with synchronous clear.
// A clear in the same cycle as an increment wins.
module sat_counter
    import count_mon_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] q_d, q_q;

    always_comb begin
        q_d = q_q;
        if (clr)
            q_d = '0;
        else if (inc)
            q_d = W'(sat_inc(32'(q_q), 32'({W{1'b1}})));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q_q <= '0;
        else
            q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/count_seq_monitor.sv
// Checks that a free-running counter advances by +1 and classifies each step.
// Wraps, upstream resets and sequence errors are only reported while locked.
module count_seq_monitor
    import count_mon_pkg::*;
#(
    parameter int CW     = CW_DEF,
    parameter int STATW  = STATW_DEF,
    parameter int LOCK_N = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CW-1:0]    count_in,
    input  logic             count_vld,
    input  logic             clr,
    output logic             locked,
    output logic             wrap_pulse,
    output logic             crst_pulse,
    output logic             err_pulse,
    output logic [STATW-1:0] wrap_cnt,
    output logic [STATW-1:0] crst_cnt,
    output logic [STATW-1:0] err_cnt
);

    state_e        state_d, state_q;
    logic [CW-1:0] prev_d, prev_q;
    logic [2:0]    good_d, good_q;
    logic          wrap_d, wrap_q;
    logic          crst_d, crst_q;
    logic          err_d, err_q;
    logic [CW-1:0] exp_v;
    logic [2:0]    good_inc;

    assign exp_v    = prev_q + CW'(1);
    assign good_inc = good_q + 3'd1;

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        good_d  = good_q;
        wrap_d  = 1'b0;
        crst_d  = 1'b0;
        err_d   = 1'b0;
        if (count_vld) begin
            prev_d = count_in;
            case (state_q)
                IDLE: begin
                    good_d  = '0;
                    state_d = ACQ;
                end
                ACQ: begin
                    if (count_in == exp_v) begin
                        good_d = good_inc;
                        if (good_inc == 3'(LOCK_N))
                            state_d = LOCK;
                    end else begin
                        good_d = '0;
                    end
                end
                LOCK: begin
                    // max->0 matches exp_v, so it is a wrap before it can look like a reset
                    if (count_in == exp_v) begin
                        wrap_d = (prev_q == {CW{1'b1}});
                    end else if (count_in == '0) begin
                        crst_d = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        good_d  = '0;
                        state_d = ACQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            prev_q  <= '0;
            good_q  <= '0;
            wrap_q  <= 1'b0;
            crst_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            good_q  <= good_d;
            wrap_q  <= wrap_d;
            crst_q  <= crst_d;
            err_q   <= err_d;
        end
    end

    assign locked     = (state_q == LOCK);
    assign wrap_pulse = wrap_q;
    assign crst_pulse = crst_q;
    assign err_pulse  = err_q;

    sat_counter #(.W(STATW)) u_wrap_cnt (
        .clk(clk), .reset(reset), .inc(wrap_d), .clr(clr), .q(wrap_cnt)
    );
    sat_counter #(.W(STATW)) u_crst_cnt (
        .clk(clk), .reset(reset), .inc(crst_d), .clr(clr), .q(crst_cnt)
    );
    sat_counter #(.W(STATW)) u_err_cnt (
        .clk(clk), .reset(reset), .inc(err_d), .clr(clr), .q(err_cnt)
    );

endmodule
